// File: rtl/edge_dect_multi.sv
// edge_dect_multi
//   Multi-channel edge detector. Each asynchronous input is synchronised,
//   then debounced by a per-channel stability counter. A change in level is
//   accepted only after the synchronised input has stayed different from the
//   filtered level for FILT_LEN consecutive cycles. Accepted changes produce
//   one-cycle rise/fall pulses. The per-channel edge_mode selects which
//   pulses count as events. Events set sticky status flags and are added to
//   a saturating event counter.
//
// Ports
//   clk        : rising-edge clock for all logic
//   rst        : asynchronous reset, active low
//   d_in       : [WIDTH] raw asynchronous channel inputs
//   edge_mode  : [2*WIDTH] per channel {fall_en, rise_en}; 00 off, 01 rise, 10 fall, 11 both
//   irq_mask   : [WIDTH] 1 masks a channel from irq (the status flag is kept)
//   irq_clr    : [WIDTH] write-1-to-clear of irq_status
//   cnt_clr    : synchronous clear of evt_cnt
//   q          : [WIDTH] filtered, registered level
//   rise_edge  : [WIDTH] one-cycle pulse on filtered 0->1
//   fall_edge  : [WIDTH] one-cycle pulse on filtered 1->0
//   irq_status : [WIDTH] sticky per-channel event flags
//   irq        : OR of unmasked status flags (combinational)
//   evt_cnt    : [CNT_W] saturating count of enabled events
module edge_dect_multi #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     d_in,
  input  logic [2*WIDTH-1:0]   edge_mode,
  input  logic [WIDTH-1:0]     irq_mask,
  input  logic [WIDTH-1:0]     irq_clr,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     rise_edge,
  output logic [WIDTH-1:0]     fall_edge,
  output logic [WIDTH-1:0]     irq_status,
  output logic                 irq,
  output logic [CNT_W-1:0]     evt_cnt
);

  // Terminal count of the stability counter: the FILT_LEN-th consecutive
  // differing cycle is the one that commits the new level.
  localparam logic [7:0] FILT_TC = 8'(FILT_LEN - 1);

  // Sum is kept wide enough that evt_cnt plus a full popcount (<= 32)
  // can never overflow before the saturation compare.
  localparam int SUM_W = CNT_W + 7;
  localparam logic [SUM_W-1:0] CNT_MAX = {7'b0, {CNT_W{1'b1}}};

  logic [SYNC_STAGES-1:0] sync_r   [WIDTH];
  logic [7:0]             stab_cnt [WIDTH];
  logic [WIDTH-1:0]       s;
  logic [WIDTH-1:0]       evt;
  logic [5:0]             evt_pop;
  logic [SUM_W-1:0]       cnt_sum;
  logic [CNT_W-1:0]       evt_cnt_nxt;

  always_comb begin
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = sync_r[i][SYNC_STAGES-1];
    end
  end

  // Synchroniser chains: bit 0 takes d_in, the top bit is the synchronised level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], d_in[i]};
      end
    end
  end

  // Glitch filter. Any cycle where s matches q restarts the count, so a
  // pulse shorter than FILT_LEN cycles never reaches q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= '0;
      rise_edge <= '0;
      fall_edge <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise_edge[i] <= 1'b0;
        fall_edge[i] <= 1'b0;
        if (s[i] == q[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == FILT_TC) begin
          q[i]         <= s[i];
          stab_cnt[i]  <= '0;
          rise_edge[i] <= s[i];
          fall_edge[i] <= ~s[i];
        end else begin
          stab_cnt[i]  <= stab_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Event qualification uses the current edge_mode, so a mode change
  // applies to pulses in the same cycle and never to past ones.
  always_comb begin
    evt     = '0;
    evt_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      evt[i]  = (rise_edge[i] & edge_mode[2*i]) | (fall_edge[i] & edge_mode[2*i+1]);
      evt_pop = evt_pop + {5'b0, evt[i]};
    end
  end

  // A clear in the same cycle as events restarts the count from those events.
  always_comb begin
    cnt_sum = (cnt_clr ? '0 : {7'b0, evt_cnt}) + {{(CNT_W+1){1'b0}}, evt_pop};
    if (cnt_sum > CNT_MAX) begin
      evt_cnt_nxt = '1;
    end else begin
      evt_cnt_nxt = cnt_sum[CNT_W-1:0];
    end
  end

  // Status: set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_status <= '0;
      evt_cnt    <= '0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | evt;
      evt_cnt    <= evt_cnt_nxt;
    end
  end

  assign irq = |(irq_status & ~irq_mask);

endmodule

// File: doc/edge_dect_multi.md
EDGE_DECT_MULTI -- requirements
Module: edge_dect_multi

Interface
REQ-001 Parameter WIDTH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel (2..4).
REQ-003 Parameter FILT_LEN, default 3, consecutive stable cycles needed to accept a level change (1..255).
REQ-004 Parameter CNT_W, default 8, width of the event counter.
REQ-005 Port clk, input, 1, single rising-edge clock for all logic.
REQ-006 Port rst, input, 1, asynchronous active-low reset (asserted when 0).
REQ-007 Port d_in, input, WIDTH, asynchronous raw channel inputs.
REQ-008 Port edge_mode, input, 2*WIDTH, per channel bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 Port irq_mask, input, WIDTH, 1 masks channel i from irq.
REQ-010 Port irq_clr, input, WIDTH, 1-cycle write-1-to-clear of irq_status.
REQ-011 Port cnt_clr, input, 1, synchronous clear of evt_cnt.
REQ-012 Port q, output, WIDTH, filtered registered level per channel.
REQ-013 Port rise_edge, output, WIDTH, 1-cycle pulse on filtered 0->1.
REQ-014 Port fall_edge, output, WIDTH, 1-cycle pulse on filtered 1->0.
REQ-015 Port irq_status, output, WIDTH, sticky per-channel event flags.
REQ-016 Port irq, output, 1, OR of irq_status & ~irq_mask.
REQ-017 Port evt_cnt, output, CNT_W, saturating count of enabled events.

Function
REQ-018 Each channel SHALL pass d_in[i] through SYNC_STAGES flops; last stage is s[i].
REQ-019 Per channel an 8-bit stability counter: s==q -> counter 0; s!=q and counter==FILT_LEN-1 -> q<=s, counter 0; else counter+1.
REQ-020 Any cycle where s returns to q before acceptance SHALL reset the counter (glitch rejected, no pulse).
REQ-021 rise_edge[i]/fall_edge[i] SHALL be registered, high exactly in the cycle q[i] holds its new value, for one cycle, regardless of edge_mode.
REQ-022 Latency: d_in change sampled at clock edge N and held stable -> q and pulse update at edge N+SYNC_STAGES+FILT_LEN-1.
REQ-023 Enabled event for channel i = (rise_edge & mode bit0) | (fall_edge & mode bit1).
REQ-024 irq_status[i] SHALL set on enabled event next cycle, clear on irq_clr[i]; simultaneous set and clear -> set wins.
REQ-025 irq SHALL be combinational from irq_status and irq_mask; masking SHALL NOT clear status.
REQ-026 evt_cnt SHALL add popcount of enabled events each cycle, saturating at 2^CNT_W-1 (no wrap).
REQ-027 cnt_clr with events in same cycle -> evt_cnt = popcount of that cycle's events.
REQ-028 edge_mode change SHALL take effect on the same cycle's events; no retroactive status.

Reset
REQ-029 While rst=0: sync flops, q, counters, rise_edge, fall_edge, irq_status, evt_cnt all 0; irq 0.
REQ-030 Reset assertion SHALL act immediately, mid-filter or mid-pulse, without waiting for clk.
REQ-031 After release, a channel whose d_in is 1 SHALL produce a normal rise_edge after REQ-022 latency.

Verification
REQ-032 Defaults, ch0 mode 01, d_in[0] 0->1 at edge 10 -> q[0]=1 and rise_edge[0] pulse at edge 14, irq_status[0]=1 at edge 15, irq=1, evt_cnt=1.
REQ-033 d_in[1] high for 2 cycles only (FILT_LEN=3) -> no q change, no pulse, evt_cnt unchanged.
REQ-034 All 4 channels mode 11, simultaneous rise -> evt_cnt +4 in one cycle; CNT_W=2 variant saturates at 3.
REQ-035 irq_clr[0] in same cycle as new enabled event on ch0 -> irq_status[0] stays 1; irq_mask[0]=1 -> irq=0, status still 1.
REQ-036 rst=0 mid-filter (counter=2) between clock edges -> all outputs 0 immediately; after release with d_in=1 -> rise at REQ-022 latency.
